spi_cs_sequencer: RTL and testbench
===================================

Name: spi_cs_sequencer

Overview:
- Upstream transaction sequencer for SPI_Master_MLF: frames multi-byte SPI transactions under one active-low chip select.
- Accepts a byte count plus a stream of TX bytes from the user side and drives the byte-level master handshake (TX_Byte/TX_DV/TX_Ready, RX_DV/RX_Byte).
- Enforces programmable CS lead, trail and inter-transaction gap times.
- Tags each returned RX byte with its index in the transaction.

Parameters:
- COUNT_W, 8, width of byte count; max transaction length 2^COUNT_W-1 bytes.
- CS_LEAD_CLKS, 2, i_clk cycles from CS_n falling to first o_M_TX_DV.
- CS_TRAIL_CLKS, 2, i_clk cycles from last i_M_RX_DV to CS_n rising.
- CS_GAP_CLKS, 4, minimum i_clk cycles CS_n stays high before next transaction may start.
- TIMEOUT_CLKS, 255, stall limit in WAIT_BYTE (used only with SPI_CS_TIMEOUT_EN).

Ports:
- i_clk  in  1  system clock, all logic on posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_TX_Count  in  COUNT_W  bytes in transaction; sampled with first i_TX_DV in IDLE.
- i_TX_Byte  in  8  user TX byte, valid with i_TX_DV.
- i_TX_DV  in  1  one-cycle byte strobe, honoured only while o_TX_Ready=1.
- o_TX_Ready  out  1  sequencer can accept a byte.
- o_RX_DV  out  1  one-cycle RX byte strobe.
- o_RX_Byte  out  8  received byte.
- o_RX_Index  out  COUNT_W  0-based index of o_RX_Byte in transaction.
- o_Busy  out  1  high from transaction accept until gap ends.
- o_Timeout  out  1  one-cycle abort pulse (0 when feature absent).
- o_M_TX_Byte  out  8  to master i_TX_Byte.
- o_M_TX_DV  out  1  to master i_TX_DV, one-cycle pulse.
- i_M_TX_Ready  in  1  from master o_TX_Ready.
- i_M_RX_DV  in  1  from master o_RX_DV.
- i_M_RX_Byte  in  8  from master o_RX_Byte.
- o_SPI_CS_n  out  1  chip select to slave, active low.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_SPI_CS_n=1.
  - o_TX_Ready=1 (IDLE).
  - o_M_TX_DV=0, o_RX_DV=0, o_Timeout=0, o_Busy=0.
  - Byte/index/counter registers 0.
  - Reset mid-transaction aborts immediately, CS_n high same as async assertion; the master is not notified.
- FSM states: IDLE, CS_LEAD, ISSUE, WAIT_RX, WAIT_BYTE, CS_TRAIL, CS_GAP.
- IDLE:
  - o_TX_Ready=1.
  - i_TX_DV with i_TX_Count=0: ignored, no CS activity.
  - i_TX_DV with count>0: latch byte, remaining=count, index=0, CS_n=0 next cycle, go to CS_LEAD.
- CS_LEAD: hold CS_LEAD_CLKS cycles, then ISSUE.
- ISSUE:
  - Wait for i_M_TX_Ready=1.
  - Then pulse o_M_TX_DV for exactly 1 cycle with the latched byte, decrement remaining, go to WAIT_RX.
- WAIT_RX: on i_M_RX_DV, register o_RX_Byte=i_M_RX_Byte, o_RX_Index=index, pulse o_RX_DV next cycle, index++.
  - remaining>0: go to WAIT_BYTE.
  - remaining=0: go to CS_TRAIL.
- WAIT_BYTE:
  - o_TX_Ready=1, CS_n held low indefinitely.
  - On i_TX_DV: latch byte, go to ISSUE. i_TX_Count is ignored.
- CS_TRAIL: hold CS_TRAIL_CLKS cycles, then CS_n=1, go to CS_GAP.
- CS_GAP: hold CS_GAP_CLKS cycles, then IDLE.
- o_TX_Ready is 0 in all states except IDLE and WAIT_BYTE. i_TX_DV in other states is dropped.
- Delay parameters equal to 0 mean the state lasts exactly 1 cycle.
- o_Busy is high in every state except IDLE.
- Max count (2^COUNT_W-1) must complete without counter wrap.
- If i_M_RX_DV and i_TX_DV coincide in WAIT_RX, i_TX_DV is dropped (o_TX_Ready was 0).

Optional Feature:
- Macro SPI_CS_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BYTE and clears on i_TX_DV.
  - On reaching TIMEOUT_CLKS with no byte: pulse o_Timeout 1 cycle, skip remaining bytes, go to CS_TRAIL (normal trail and gap).
- Undefined:
  - No counter; WAIT_BYTE waits forever.
  - o_Timeout tied to 0.

Test Plan:
- Single byte: count=1, byte 0xC1, master model loops MOSI->MISO.
  - CS_n low 2 clks before M_TX_DV.
  - RX 0xC1 index 0.
  - CS_n high 2 clks after M_RX_DV.
  - o_Busy low 4 clks later.
- Three-byte burst 0xBE,0xEF,0x5A (count=3):
  - CS_n stays low across all three.
  - Three RX_DV pulses with indices 0,1,2 and looped data.
  - Exactly one CS_n falling and one rising edge.
- Count=0 with i_TX_DV:
  - No CS_n activity, o_Busy stays 0, o_TX_Ready stays 1.
- Stalled producer: count=2, second byte supplied 100 clks late:
  - CS_n held low for the full stall.
  - Both bytes returned.
  - (With SPI_CS_TIMEOUT_EN, TIMEOUT_CLKS=50: o_Timeout pulse at ~50 clks, CS_n rises after trail, only 1 RX_DV.)
- Back-to-back transactions:
  - Second i_TX_DV during CS_GAP is dropped.
  - Next accepted only in IDLE.
  - CS_n high ≥4 clks between transactions.
- Reset asserted mid-byte of a 3-byte transaction:
  - CS_n=1 and o_TX_Ready=1 immediately.
  - No further M_TX_DV after reset release until a new i_TX_DV.

Source files
------------

// File: rtl/spi_cs_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_cs_sequencer
// Brief    : Frames multi-byte SPI transactions under one active-low chip
//            select in front of SPI_Master_MLF. Defining SPI_CS_TIMEOUT_EN
//            adds a producer-stall abort in WAIT_BYTE.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cs_sequencer #(
    parameter int COUNT_W       = 8,
    parameter int CS_LEAD_CLKS  = 2,
    parameter int CS_TRAIL_CLKS = 2,
    parameter int CS_GAP_CLKS   = 4,
    parameter int TIMEOUT_CLKS  = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [COUNT_W-1:0] i_TX_Count,
    input  logic [7:0]         i_TX_Byte,
    input  logic               i_TX_DV,
    output logic               o_TX_Ready,
    output logic               o_RX_DV,
    output logic [7:0]         o_RX_Byte,
    output logic [COUNT_W-1:0] o_RX_Index,
    output logic               o_Busy,
    output logic               o_Timeout,
    output logic [7:0]         o_M_TX_Byte,
    output logic               o_M_TX_DV,
    input  logic               i_M_TX_Ready,
    input  logic               i_M_RX_DV,
    input  logic [7:0]         i_M_RX_Byte,
    output logic               o_SPI_CS_n
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CS_LEAD   = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_RX   = 3'd3,
        S_WAIT_BYTE = 3'd4,
        S_CS_TRAIL  = 3'd5,
        S_CS_GAP    = 3'd6
    } state_t;

    // Shared dwell counter is sized for the longest of all programmable delays.
    localparam int C_MAX_A   = (CS_LEAD_CLKS > CS_TRAIL_CLKS) ? CS_LEAD_CLKS : CS_TRAIL_CLKS;
    localparam int C_MAX_B   = (CS_GAP_CLKS > TIMEOUT_CLKS) ? CS_GAP_CLKS : TIMEOUT_CLKS;
    localparam int C_DLY_MAX = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
    localparam int DLY_W     = $clog2(C_DLY_MAX + 2);

    // Lead and trail each dwell one cycle less than their parameter: the
    // registered o_M_TX_DV / o_SPI_CS_n edge supplies the remaining cycle.
    localparam logic [DLY_W-1:0] C_LEAD_LAST  = (CS_LEAD_CLKS > 1)  ? DLY_W'(CS_LEAD_CLKS - 2)  : '0;
    localparam logic [DLY_W-1:0] C_TRAIL_LAST = (CS_TRAIL_CLKS > 1) ? DLY_W'(CS_TRAIL_CLKS - 2) : '0;
    localparam logic [DLY_W-1:0] C_GAP_LAST   = (CS_GAP_CLKS > 0)   ? DLY_W'(CS_GAP_CLKS - 1)   : '0;
`ifdef SPI_CS_TIMEOUT_EN
    localparam logic [DLY_W-1:0] C_TO_LAST    = (TIMEOUT_CLKS > 0)  ? DLY_W'(TIMEOUT_CLKS - 1)  : '0;
`endif

    state_t             state_q,     state_d;
    logic               cs_n_q,      cs_n_d;
    logic               tx_ready_q,  tx_ready_d;
    logic               busy_q,      busy_d;
    logic               m_tx_dv_q,   m_tx_dv_d;
    logic [7:0]         m_tx_byte_q, m_tx_byte_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [COUNT_W-1:0] index_q,     index_d;
    logic               rx_dv_q,     rx_dv_d;
    logic [7:0]         rx_byte_q,   rx_byte_d;
    logic [COUNT_W-1:0] rx_index_q,  rx_index_d;
    logic [DLY_W-1:0]   dly_q,       dly_d;
`ifdef SPI_CS_TIMEOUT_EN
    logic               timeout_q,   timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        cs_n_d      = cs_n_q;
        m_tx_dv_d   = 1'b0;
        m_tx_byte_d = m_tx_byte_q;
        remaining_d = remaining_q;
        index_d     = index_q;
        rx_dv_d     = 1'b0;
        rx_byte_d   = rx_byte_q;
        rx_index_d  = rx_index_q;
        dly_d       = dly_q;
`ifdef SPI_CS_TIMEOUT_EN
        timeout_d   = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_TX_DV && (i_TX_Count != '0)) begin
                    m_tx_byte_d = i_TX_Byte;
                    remaining_d = i_TX_Count;
                    index_d     = '0;
                    dly_d       = '0;
                    cs_n_d      = 1'b0;
                    state_d     = S_CS_LEAD;
                end
            end

            S_CS_LEAD: begin
                if (dly_q >= C_LEAD_LAST) begin
                    dly_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end

            S_ISSUE: begin
                if (i_M_TX_Ready) begin
                    m_tx_dv_d   = 1'b1;
                    remaining_d = remaining_q - COUNT_W'(1);
                    state_d     = S_WAIT_RX;
                end
            end

            S_WAIT_RX: begin
                // A user strobe arriving here is dropped: o_TX_Ready is low.
                if (i_M_RX_DV) begin
                    rx_dv_d    = 1'b1;
                    rx_byte_d  = i_M_RX_Byte;
                    rx_index_d = index_q;
                    index_d    = index_q + COUNT_W'(1);
                    dly_d      = '0;
                    state_d    = (remaining_q != '0) ? S_WAIT_BYTE : S_CS_TRAIL;
                end
            end

            S_WAIT_BYTE: begin
                if (i_TX_DV) begin
                    m_tx_byte_d = i_TX_Byte;
                    dly_d       = '0;
                    state_d     = S_ISSUE;
                end
`ifdef SPI_CS_TIMEOUT_EN
                else if (dly_q >= C_TO_LAST) begin
                    timeout_d = 1'b1;
                    dly_d     = '0;
                    state_d   = S_CS_TRAIL;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
`endif
            end

            S_CS_TRAIL: begin
                if (dly_q >= C_TRAIL_LAST) begin
                    cs_n_d  = 1'b1;
                    dly_d   = '0;
                    state_d = S_CS_GAP;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end

            S_CS_GAP: begin
                if (dly_q >= C_GAP_LAST) begin
                    dly_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end

            default: begin
                cs_n_d  = 1'b1;
                dly_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        tx_ready_d = (state_d == S_IDLE) || (state_d == S_WAIT_BYTE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cs_n_q      <= 1'b1;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            m_tx_dv_q   <= 1'b0;
            m_tx_byte_q <= '0;
            remaining_q <= '0;
            index_q     <= '0;
            rx_dv_q     <= 1'b0;
            rx_byte_q   <= '0;
            rx_index_q  <= '0;
            dly_q       <= '0;
`ifdef SPI_CS_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cs_n_q      <= cs_n_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            m_tx_dv_q   <= m_tx_dv_d;
            m_tx_byte_q <= m_tx_byte_d;
            remaining_q <= remaining_d;
            index_q     <= index_d;
            rx_dv_q     <= rx_dv_d;
            rx_byte_q   <= rx_byte_d;
            rx_index_q  <= rx_index_d;
            dly_q       <= dly_d;
`ifdef SPI_CS_TIMEOUT_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign o_TX_Ready  = tx_ready_q;
    assign o_RX_DV     = rx_dv_q;
    assign o_RX_Byte   = rx_byte_q;
    assign o_RX_Index  = rx_index_q;
    assign o_Busy      = busy_q;
    assign o_M_TX_Byte = m_tx_byte_q;
    assign o_M_TX_DV   = m_tx_dv_q;
    assign o_SPI_CS_n  = cs_n_q;
`ifdef SPI_CS_TIMEOUT_EN
    assign o_Timeout   = timeout_q;
`else
    assign o_Timeout   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_cs_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cs_sequencer
// Brief    : Scoreboard bench for spi_cs_sequencer with a loopback master model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cs_sequencer;

    localparam int COUNT_W       = 8;
    localparam int CS_LEAD_CLKS  = 2;
    localparam int CS_TRAIL_CLKS = 2;
    localparam int CS_GAP_CLKS   = 4;
    localparam int TIMEOUT_CLKS  = 50;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [COUNT_W-1:0] i_TX_Count;
    logic [7:0]         i_TX_Byte;
    logic               i_TX_DV;
    logic               o_TX_Ready, o_RX_DV, o_Busy, o_Timeout, o_M_TX_DV, o_SPI_CS_n;
    logic [7:0]         o_RX_Byte, o_M_TX_Byte;
    logic [COUNT_W-1:0] o_RX_Index;
    logic               m_ready, m_rx_dv;
    logic [7:0]         m_rx_byte;

    always #5 clk = ~clk;

    spi_cs_sequencer #(
        .COUNT_W(COUNT_W), .CS_LEAD_CLKS(CS_LEAD_CLKS), .CS_TRAIL_CLKS(CS_TRAIL_CLKS),
        .CS_GAP_CLKS(CS_GAP_CLKS), .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_TX_Count(i_TX_Count), .i_TX_Byte(i_TX_Byte), .i_TX_DV(i_TX_DV),
        .o_TX_Ready(o_TX_Ready), .o_RX_DV(o_RX_DV), .o_RX_Byte(o_RX_Byte),
        .o_RX_Index(o_RX_Index), .o_Busy(o_Busy), .o_Timeout(o_Timeout),
        .o_M_TX_Byte(o_M_TX_Byte), .o_M_TX_DV(o_M_TX_DV), .i_M_TX_Ready(m_ready),
        .i_M_RX_DV(m_rx_dv), .i_M_RX_Byte(m_rx_byte), .o_SPI_CS_n(o_SPI_CS_n)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic fail_wait(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Expected RX stream: byte k of a transaction comes back looped with index k.
    typedef struct packed {
        logic [7:0]         b;
        logic [COUNT_W-1:0] idx;
    } rx_t;
    rx_t exp_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Loopback master: one byte in flight, MISO returns MOSI after a random delay.
    logic       m_pend = 1'b0;
    logic [7:0] m_pend_b;
    int         m_lat;
    initial begin : master_model
        m_ready   = 1'b1;
        m_rx_dv   = 1'b0;
        m_rx_byte = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (m_rx_dv) begin
                m_rx_dv = 1'b0;
                m_ready = 1'b1;
            end
            if (m_pend) begin
                if (m_lat == 0) begin
                    m_rx_dv   = 1'b1;
                    m_rx_byte = m_pend_b;
                    m_pend    = 1'b0;
                end else begin
                    m_lat--;
                end
            end else if (o_M_TX_DV && rst_n) begin
                m_pend   = 1'b1;
                m_pend_b = o_M_TX_Byte;
                m_lat    = int'($urandom_range(1, 5));
                m_ready  = 1'b0;
            end
        end
    end

    // Event recorder for CS framing and handshake timing.
    int  cs_fall_cyc = -1, cs_rise_cyc = -1, first_mdv_cyc = -1, last_mrx_cyc = -1;
    int  busy_fall_cyc = -1, to_cyc = -1;
    int  n_fall = 0, n_rise = 0, mdv_cnt = 0, rx_seen = 0, to_cnt = 0;
    int  busy_hi = 0, rdy_lo = 0;
    logic prev_cs = 1'b1, prev_busy = 1'b0;
    initial begin : mon_events
        forever begin
            @(negedge clk);
            if (prev_cs && !o_SPI_CS_n) begin
                n_fall++;
                if (cs_fall_cyc < 0) cs_fall_cyc = cyc;
            end
            if (!prev_cs && o_SPI_CS_n) begin
                n_rise++;
                cs_rise_cyc = cyc;
            end
            if (prev_busy && !o_Busy) busy_fall_cyc = cyc;
            if (o_M_TX_DV) begin
                mdv_cnt++;
                if (first_mdv_cyc < 0) first_mdv_cyc = cyc;
            end
            if (m_rx_dv && !o_SPI_CS_n) last_mrx_cyc = cyc;
            if (o_Timeout) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (o_Busy) busy_hi++;
            if (!o_TX_Ready) rdy_lo++;
            prev_cs   = o_SPI_CS_n;
            prev_busy = o_Busy;
        end
    end

    initial begin : mon_rx
        rx_t e;
        forever begin
            @(negedge clk);
            if (o_RX_DV === 1'b1) begin
                rx_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_unexpected: actual byte=%0d index=%0d required=no strobe", o_RX_Byte, o_RX_Index);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte", 64'(o_RX_Byte), 64'(e.b));
                    check("rx_index", 64'(o_RX_Index), 64'(e.idx));
                end
            end
        end
    end

    task automatic clear_events();
        cs_fall_cyc = -1; cs_rise_cyc = -1; first_mdv_cyc = -1; last_mrx_cyc = -1;
        busy_fall_cyc = -1; to_cyc = -1;
        n_fall = 0; n_rise = 0; mdv_cnt = 0; rx_seen = 0; to_cnt = 0;
        busy_hi = 0; rdy_lo = 0;
    endtask

    task automatic wait_idle();
        int g = 0;
        @(posedge clk); #1;
        while (!(o_Busy == 1'b0 && o_TX_Ready == 1'b1 && m_ready && !m_pend) && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 2000) fail_wait("wait_idle");
    endtask

    task automatic pulse_tx(input logic [COUNT_W-1:0] cnt, input logic [7:0] b);
        i_TX_Count = cnt;
        i_TX_Byte  = b;
        i_TX_DV    = 1'b1;
        @(posedge clk); #1;
        i_TX_DV    = 1'b0;
        i_TX_Byte  = 8'h00;
    endtask

    task automatic run_txn(input logic [7:0] b[$], input int dly[$], input bit gap_poke);
        int  n, n_issued, g, prev_rise;
        bit  timed_out;
        n = b.size();
        wait_idle();
        prev_rise = cs_rise_cyc;
        clear_events();
        timed_out = 1'b0;
        exp_q.push_back(rx_t'{b[0], COUNT_W'(0)});
        pulse_tx(COUNT_W'(n), b[0]);
        n_issued = 1;
        for (int i = 1; i < n; i++) begin
            g = 0;
            while (!o_TX_Ready && g < 500) begin
                @(posedge clk); #1;
                g++;
            end
            if (!o_TX_Ready) begin
                fail_wait("wait_tx_ready");
                break;
            end
`ifdef SPI_CS_TIMEOUT_EN
            if (dly[i] >= TIMEOUT_CLKS) begin
                timed_out = 1'b1;
                break;
            end
`endif
            for (int k = 0; k < dly[i]; k++) begin
                @(posedge clk); #1;
            end
            exp_q.push_back(rx_t'{b[i], COUNT_W'(i)});
            pulse_tx(COUNT_W'($urandom_range(0, 255)), b[i]);
            n_issued++;
        end
        if (gap_poke) begin
            g = 0;
            while (o_SPI_CS_n == 1'b0 && g < 500) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 500) fail_wait("wait_cs_rise");
            pulse_tx(COUNT_W'(1), 8'h77);
        end
        g = 0;
        while (o_Busy && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 3000) fail_wait("wait_busy_low");
        repeat (2) @(negedge clk);
        check("cs_fall_edges", 64'(n_fall), 64'd1);
        check("cs_rise_edges", 64'(n_rise), 64'd1);
        check("m_tx_dv_pulses", 64'(mdv_cnt), 64'(n_issued));
        check("rx_strobes", 64'(rx_seen), 64'(n_issued));
        check("rx_pending", 64'(exp_q.size()), 64'd0);
        check("cs_lead_clks", 64'(first_mdv_cyc - cs_fall_cyc), 64'(CS_LEAD_CLKS));
        check("cs_gap_to_idle", 64'(busy_fall_cyc - cs_rise_cyc), 64'(CS_GAP_CLKS));
        if (!timed_out) check("cs_trail_clks", 64'(cs_rise_cyc - last_mrx_cyc), 64'(CS_TRAIL_CLKS));
        if (prev_rise >= 0) check("cs_high_between", 64'(cs_fall_cyc - prev_rise >= CS_GAP_CLKS), 64'd1);
`ifdef SPI_CS_TIMEOUT_EN
        check("timeout_pulses", 64'(to_cnt), timed_out ? 64'd1 : 64'd0);
        if (timed_out) begin
            check("timeout_delay_window",
                  64'((to_cyc - last_mrx_cyc >= TIMEOUT_CLKS - 2) && (to_cyc - last_mrx_cyc <= TIMEOUT_CLKS + 3)), 64'd1);
        end
`else
        check("timeout_pulses", 64'(to_cnt), 64'd0);
`endif
        exp_q.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [7:0] bq[$];
        int         dq[$];
        int         n, g, snap;

        rst_n      = 1'b0;
        i_TX_Count = '0;
        i_TX_Byte  = 8'h00;
        i_TX_DV    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 64'(o_SPI_CS_n), 64'd1);
        check("rst_tx_ready", 64'(o_TX_Ready), 64'd1);
        check("rst_m_tx_dv", 64'(o_M_TX_DV), 64'd0);
        check("rst_rx_dv", 64'(o_RX_DV), 64'd0);
        check("rst_timeout", 64'(o_Timeout), 64'd0);
        check("rst_busy", 64'(o_Busy), 64'd0);
        check("rst_rx_byte", 64'(o_RX_Byte), 64'd0);
        check("rst_rx_index", 64'(o_RX_Index), 64'd0);
        check("rst_m_tx_byte", 64'(o_M_TX_Byte), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single byte
        bq.delete(); dq.delete();
        bq.push_back(8'hC1); dq.push_back(0);
        run_txn(bq, dq, 1'b0);

        // Three-byte burst
        bq.delete(); dq.delete();
        bq.push_back(8'hBE); bq.push_back(8'hEF); bq.push_back(8'h5A);
        dq.push_back(0); dq.push_back(0); dq.push_back(3);
        run_txn(bq, dq, 1'b0);

        // Zero count is ignored entirely
        wait_idle();
        clear_events();
        pulse_tx(COUNT_W'(0), 8'h33);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("cnt0_cs_edges", 64'(n_fall), 64'd0);
        check("cnt0_busy_cycles", 64'(busy_hi), 64'd0);
        check("cnt0_ready_low_cycles", 64'(rdy_lo), 64'd0);
        check("cnt0_m_tx_dv", 64'(mdv_cnt), 64'd0);

        // Stalled producer: second byte 100 clocks late
        bq.delete(); dq.delete();
        bq.push_back(8'h3C); bq.push_back(8'hA5);
        dq.push_back(0); dq.push_back(100);
        run_txn(bq, dq, 1'b0);
`ifndef SPI_CS_TIMEOUT_EN
        check("stall_cs_low_span", 64'(cs_rise_cyc - cs_fall_cyc > 100), 64'd1);
`endif

        // Strobe during CS_GAP is dropped, then an immediate follow-on
        bq.delete(); dq.delete();
        bq.push_back(8'h11); bq.push_back(8'h22);
        dq.push_back(0); dq.push_back(0);
        run_txn(bq, dq, 1'b1);
        repeat (8) @(negedge clk);
        check("gap_strobe_dropped", 64'(n_fall), 64'd1);
        bq.delete(); dq.delete();
        bq.push_back(8'h44); dq.push_back(0);
        run_txn(bq, dq, 1'b0);

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            bq.delete(); dq.delete();
            n = int'($urandom_range(1, 6));
            for (int j = 0; j < n; j++) begin
                bq.push_back(8'($urandom));
                dq.push_back(int'($urandom_range(0, 5)));
            end
            run_txn(bq, dq, 1'b0);
        end

        // Maximum length transaction
        bq.delete(); dq.delete();
        for (int j = 0; j < 255; j++) begin
            bq.push_back(8'($urandom));
            dq.push_back(0);
        end
        run_txn(bq, dq, 1'b0);

        // Reset in the middle of byte 1 of a 3-byte transaction
        wait_idle();
        clear_events();
        exp_q.push_back(rx_t'{8'hD1, COUNT_W'(0)});
        pulse_tx(COUNT_W'(3), 8'hD1);
        g = 0;
        while (!o_TX_Ready && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 500) fail_wait("rst_mid_ready");
        pulse_tx(COUNT_W'(0), 8'hD2);
        g = 0;
        while (mdv_cnt < 2 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) fail_wait("rst_mid_second_dv");
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_cs_n", 64'(o_SPI_CS_n), 64'd1);
        check("rst_mid_tx_ready", 64'(o_TX_Ready), 64'd1);
        check("rst_mid_busy", 64'(o_Busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        snap = mdv_cnt;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("rst_mid_no_more_m_tx_dv", 64'(mdv_cnt), 64'(snap));
        check("rst_mid_cs_idle", 64'(o_SPI_CS_n), 64'd1);

        // Recovery after reset
        bq.delete(); dq.delete();
        bq.push_back(8'h96); bq.push_back(8'h69);
        dq.push_back(0); dq.push_back(1);
        run_txn(bq, dq, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
